instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writes a program into the instruction memory before execution. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Issues one write per word at consecutive word addresses starting at 0. It is the write-side counterpart of the instruction memory read port and sits between the host/boot interface and the memory's write port.

## Interface
Parameters:
- DEPTH, 1001: number of instruction words in memory (valid addresses 0..DEPTH-1)
- ADDR_WIDTH, 64: width of word address, matches memory read address width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- numWords  in  ADDR_WIDTH  number of words to load; sampled on accepted start
- byteIn  in  8  stream data byte
- byteValid  in  1  byteIn is valid
- byteReady  out  1  loader can accept a byte this cycle
- writeEnable  out  1  memory write strobe, one cycle per word
- writeAddress  out  ADDR_WIDTH  word address for the write
- writeData  out  32  assembled instruction word
- busy  out  1  high in COLLECT and WRITE
- done  out  1  high in DONE
- overflow  out  1  numWords exceeded DEPTH and was clamped; valid from start until next start

## Operation
- The states are IDLE, COLLECT, WRITE and DONE, encoded as a 2-bit state.
- IDLE:
  - byteReady=0 and writeEnable=0.
  - On start, latch target = min(numWords, DEPTH), set overflow = (numWords > DEPTH), and clear wordIndex and byteCount.
  - If target==0 go to DONE, otherwise go to COLLECT.
- COLLECT:
  - byteReady=1.
  - On byteValid&&byteReady, place byteIn at bits [8*byteCount+7 : 8*byteCount] of the assembly register (first byte is LSB), then increment byteCount (2 bits).
  - When the 4th byte is accepted (byteCount==3), go to WRITE.
- WRITE:
  - byteReady=0.
  - writeEnable=1, writeAddress=wordIndex, writeData=assembly register; all three are registered outputs.
  - Next cycle: if wordIndex+1==target go to DONE, else increment wordIndex and return to COLLECT.
- DONE:
  - done=1, byteReady=0.
  - Bytes offered in this state are not accepted.
  - start re-launches exactly as from IDLE.
- start while busy is ignored.
- numWords is not re-sampled mid-load.
- Reset takes priority over everything:
  - All outputs go to 0: byteReady, writeEnable, writeAddress, writeData, busy, done, overflow.
  - State goes to IDLE and the counters and assembly register clear.
  - A partial word in progress is discarded and never written.
- Arithmetic:
  - wordIndex and target are ADDR_WIDTH wide.
  - The comparison wordIndex+1==target never wraps, because target ≤ DEPTH.

## Timing
- Byte accept: the same cycle in which byteValid&&byteReady is high at posedge.
- Latency: 4th byte accepted at edge k → writeEnable high during cycle k+1 (one cycle only).
- After the final write, done is high from cycle k+2.
- Peak throughput: 4 bytes per 5 cycles, because byteReady drops for the WRITE cycle.
- byteValid may stay high across the WRITE cycle. The byte is held by the source and accepted on return to COLLECT, with no loss or duplication.
- start to first byteReady: 1 cycle.
- start with numWords=0: done high after 1 cycle, with no writes.

## Structure
- Shared package: state encoding constants (IDLE=0, COLLECT=1, WRITE=2, DONE=3) and the BYTES_PER_WORD=4 constant.
- The memory's read path must not be modified.
- No sub-module is needed. Optionally, the byte-to-word assembler (shift/insert register plus byteCount) can be split out as word_assembler.
- The memory must gain a write port (writeEnable/writeAddress/writeData) in a separate change. That change is outside this block.

## Test plan
- Single word, numWords=1: bytes E5,03,1F,8B with byteValid held high → one write, addr 0, data 8B1F03E5; done high 2 cycles after the 4th byte.
- Four words with the byte streams of 8B1F03E5, F84000A4, 8B040086, F80010A6 → writes at addresses 0..3 in order with exactly those values, then done; 4 writeEnable pulses total.
- Gapped handshake: byteValid toggled pseudo-randomly, plus byteValid held through the WRITE cycle → the same words as above, no dropped or duplicated bytes; byteReady=0 in every WRITE cycle.
- numWords=0 → no writeEnable, done=1 one cycle after start, overflow=0.
- numWords=1005 with DEPTH=1001 → overflow=1, exactly 1001 writes (last address 1000), then done.
- Reset after 2 bytes of word 1 → all outputs 0 next cycle and no write of the partial word. A subsequent start and numWords=1 load of 12345678 writes address 0 = 12345678.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared state encoding and word geometry for the instruction loader
package instruction_loader_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH      = 1001,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] numWords,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [31:0]           writeData,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]            LAST    = 2'(BYTES_PER_WORD - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] target_q, word_idx_q, waddr_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           asm_q, asm_d, wdata_q;
    logic                  we_q, overflow_q;

    always_comb begin
        asm_d = asm_q;
        asm_d[{byte_cnt_q, 3'b000} +: 8] = byteIn;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (start) begin
                    target_q   <= (numWords > DEPTH_W) ? DEPTH_W : numWords;
                    overflow_q <= numWords > DEPTH_W;
                    word_idx_q <= '0;
                    byte_cnt_q <= '0;
                    state_q    <= (numWords == '0) ? DONE : COLLECT;
                end
                COLLECT: if (byteValid) begin
                    asm_q      <= asm_d;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST) begin
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                        waddr_q <= word_idx_q;
                        wdata_q <= asm_d;
                    end
                end
                WRITE: begin
                    // target never exceeds DEPTH, so word_idx_q + 1 cannot wrap
                    if (word_idx_q + ONE == target_q) begin
                        state_q <= DONE;
                    end else begin
                        word_idx_q <= word_idx_q + ONE;
                        state_q    <= COLLECT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byteReady    = state_q == COLLECT;
    assign busy         = (state_q == COLLECT) || (state_q == WRITE);
    assign done         = state_q == DONE;
    assign writeEnable  = we_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized byte-stream bench checking writes against an expected word list
module tb_instruction_loader;
    localparam int AW = 64;
    localparam int DEPTH = 1001;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] numWords = '0;
    logic [7:0]    byteIn = '0;
    logic          byteValid = 1'b0;
    logic          byteReady, writeEnable, busy, done, overflow;
    logic [AW-1:0] writeAddress;
    logic [31:0]   writeData;

    int checks = 0;
    int fails = 0;
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [31:0]   words[$];

    instruction_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .numWords(numWords),
        .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // every write is captured; byteReady must be low whenever a write is in flight
    always @(negedge clock) begin
        if (writeEnable) begin
            got_addr.push_back(writeAddress);
            got_data.push_back(writeData);
            checks++;
            if (byteReady !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write: byteReady=%b expected 0", byteReady);
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] n);
        @(posedge clock); #1;
        start = 1'b1;
        numWords = n;
        @(posedge clock); #1;
        start = 1'b0;
        numWords = {$urandom, $urandom};
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        bit ok = 1'b0;
        if (gapped) begin
            repeat ($urandom_range(0, 2)) begin
                byteValid = 1'b0;
                @(posedge clock); #1;
                start = 1'b0;
            end
        end
        byteValid = 1'b1;
        byteIn = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            ok = byteReady;
            @(posedge clock); #1;
            start = 1'b0;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL byte_accept_timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic feed_words(input int n, input bit gapped, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (i * 4 + b == pulse_at) begin
                    start = 1'b1;
                    numWords = 1;
                end
                send_byte(words[i][8*b +: 8], gapped);
            end
        end
        byteValid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clock);
            seen = done;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_done: done=%b expected 1 within 50 cycles", name, done);
        end
    endtask

    // expected writes: the first min(n, DEPTH) words at addresses 0, 1, 2, ...
    task automatic check_writes(input string name, input int n);
        int exp_n = (n > DEPTH) ? DEPTH : n;
        checks++;
        if (got_addr.size() != exp_n) begin
            fails++;
            $display("FAIL %s_count: writes=%0d expected %0d", name, got_addr.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== words[i]) begin
                fails++;
                $display("FAIL %s_write%0d: addr=%0d data=%h expected addr=%0d data=%h",
                         name, i, got_addr[i], got_data[i], i, words[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({byteReady, writeEnable, busy, done, overflow} !== 5'b0 ||
            writeAddress !== '0 || writeData !== '0) begin
            fails++;
            $display("FAIL %s: rdy=%b we=%b addr=%0d data=%h busy=%b done=%b ovf=%b expected all 0",
                     name, byteReady, writeEnable, writeAddress, writeData, busy, done, overflow);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        words = '{32'h8B1F03E5};
        got_addr.delete(); got_data.delete();
        do_start(1);
        checks++;
        if (byteReady !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: byteReady=%b busy=%b expected 1 1", byteReady, busy);
        end
        for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8], 1'b0);
        checks++;
        if (writeEnable !== 1'b1 || writeAddress !== '0 || writeData !== 32'h8B1F03E5) begin
            fails++;
            $display("FAIL single_write: we=%b addr=%0d data=%h expected 1 0 8b1f03e5",
                     writeEnable, writeAddress, writeData);
        end
        byteValid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (writeEnable !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done_timing: we=%b done=%b busy=%b expected 0 1 0",
                     writeEnable, done, busy);
        end
        repeat (2) @(posedge clock);
        check_writes("single", 1);
    endtask

    task automatic test_four_words();
        words = '{32'h8B1F03E5, 32'hF84000A4, 32'h8B040086, 32'hF80010A6};
        got_addr.delete(); got_data.delete();
        do_start(4);
        feed_words(4, 1'b0, 6);  // start pulsed mid-load must be ignored
        wait_done("four");
        check_writes("four", 4);
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL four_overflow: overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_gapped();
        words = '{32'h8B1F03E5, 32'hF84000A4, 32'h8B040086, 32'hF80010A6};
        repeat (4) words.push_back($urandom);
        got_addr.delete(); got_data.delete();
        do_start(8);
        feed_words(8, 1'b1, -1);
        wait_done("gapped");
        check_writes("gapped", 8);
    endtask

    task automatic test_zero();
        got_addr.delete(); got_data.delete();
        do_start(0);
        checks++;
        if (done !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b overflow=%b busy=%b expected 1 0 0", done, overflow, busy);
        end
        repeat (5) @(posedge clock);
        check_writes("zero", 0);
    endtask

    task automatic test_overflow();
        words.delete();
        for (int i = 0; i < 1005; i++) words.push_back($urandom);
        got_addr.delete(); got_data.delete();
        do_start(1005);
        checks++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag: overflow=%b expected 1", overflow);
        end
        feed_words(DEPTH, 1'b0, -1);
        wait_done("ovf");
        check_writes("ovf", 1005);
        checks++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_hold: overflow=%b expected 1", overflow);
        end
    endtask

    task automatic test_reset_mid();
        got_addr.delete(); got_data.delete();
        do_start(2);
        send_byte(8'hE5, 1'b0);
        send_byte(8'h03, 1'b0);
        byteValid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        check_all_zero("reset_mid");
        reset = 1'b0;
        repeat (4) @(posedge clock);
        check_writes("reset_partial", 0);
        words = '{32'h12345678};
        do_start(1);
        feed_words(1, 1'b1, -1);
        wait_done("after_reset");
        check_writes("after_reset", 1);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_four_words();
        test_gapped();
        test_zero();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
